// File: rtl/connect4_win_scanner_if.sv
// Interface for the Connect 4 win scanner.
// It carries the start/busy/done handshake and the result fields to the game FSM.
// It also carries the combinational board read port (rd_addr out, rd_data back).
//   master : game FSM plus board store side. Drives start, player and rd_data.
//   slave  : scanner side. Drives rd_addr, busy, done, win, win_anchor and win_dir.
interface connect4_win_scanner_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              start;
  logic [1:0]        player;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        rd_data;
  logic              busy;
  logic              done;
  logic              win;
  logic [ADDR_W-1:0] win_anchor;
  logic [1:0]        win_dir;

  modport master (
    output start, player, rd_data,
    input  rd_addr, busy, done, win, win_anchor, win_dir
  );

  modport slave (
    input  start, player, rd_data,
    output rd_addr, busy, done, win, win_anchor, win_dir
  );
endinterface

// File: rtl/connect4_win_scanner.sv
// Sequential four-in-a-row detector for a ROWS x COLS Connect 4 board.
// Board index = row*COLS + col, and row 0 is the top row.
// One combo is an anchor (r,c) plus a direction d. The scanner evaluates combos in order r, c, d.
// It steps k over the four cells of a valid combo and exits early on the first complete line.
// Ports:
//   CLOCK_50     : clock, rising edge
//   Resetn       : asynchronous active-low reset
//   bus.start    : scan request, accepted only in idle
//   bus.player   : cell code to look for (01/10), latched on accept
//   bus.rd_addr  : board read address (0 outside scan or on invalid combos)
//   bus.rd_data  : board cell at rd_addr, same-cycle
//   bus.busy     : high while scanning and during the done cycle
//   bus.done     : one-cycle result-valid pulse
//   bus.win      : line found
//   bus.win_anchor : first cell of the line
//   bus.win_dir    : 0 right, 1 down, 2 down-right, 3 down-left
module connect4_win_scanner #(
  parameter int unsigned ROWS   = 6,
  parameter int unsigned COLS   = 7,
  parameter int unsigned ADDR_W = 6
) (
  input  logic                   CLOCK_50,
  input  logic                   Resetn,
  connect4_win_scanner_if.slave  bus
);

  localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned ColW = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e            state_q;
  logic [RowW-1:0]   r_q;
  logic [ColW-1:0]   c_q;
  logic [1:0]        d_q;
  logic [1:0]        k_q;
  logic [1:0]        player_q;
  logic              done_q;
  logic              win_q;
  logic [ADDR_W-1:0] anchor_q;
  logic [1:0]        dir_q;

  // Combo evaluation. This logic is purely combinational from the scan registers.
  logic [31:0]       row_a, col_a, kk, row_c, col_c;
  logic              combo_valid;
  logic              match;
  logic              last_combo;
  logic [ADDR_W-1:0] cell_addr;
  logic [ADDR_W-1:0] anchor_addr;

  always_comb begin
    row_a       = 32'(r_q);
    col_a       = 32'(c_q);
    kk          = 32'(k_q);
    row_c       = row_a;
    col_c       = col_a;
    combo_valid = 1'b0;
    unique case (d_q)
      2'd0: begin
        combo_valid = (col_a <= COLS - 32'd4);
        col_c       = col_a + kk;
      end
      2'd1: begin
        combo_valid = (row_a <= ROWS - 32'd4);
        row_c       = row_a + kk;
      end
      2'd2: begin
        combo_valid = (col_a <= COLS - 32'd4) && (row_a <= ROWS - 32'd4);
        row_c       = row_a + kk;
        col_c       = col_a + kk;
      end
      default: begin
        // col_c may wrap when the combo is invalid. That is harmless because the address is masked.
        combo_valid = (col_a >= 32'd3) && (row_a <= ROWS - 32'd4);
        row_c       = row_a + kk;
        col_c       = col_a - kk;
      end
    endcase
    cell_addr   = ADDR_W'(row_c * COLS + col_c);
    anchor_addr = ADDR_W'(row_a * COLS + col_a);
    // player_q is only ever 01/10 in scan, so a cell value of 11 can never match.
    match       = combo_valid && (bus.rd_data == player_q);
    last_combo  = (r_q == RowW'(ROWS - 1)) && (c_q == ColW'(COLS - 1)) && (d_q == 2'd3);
  end

  assign bus.rd_addr    = ((state_q == StScan) && combo_valid) ? cell_addr : '0;
  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = done_q;
  assign bus.win        = win_q;
  assign bus.win_anchor = anchor_q;
  assign bus.win_dir    = dir_q;

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= StIdle;
      r_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      k_q      <= '0;
      player_q <= '0;
      done_q   <= 1'b0;
      win_q    <= 1'b0;
      anchor_q <= '0;
      dir_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            player_q <= bus.player;
            r_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            k_q      <= '0;
            win_q    <= 1'b0;
            anchor_q <= '0;
            dir_q    <= '0;
            if ((bus.player == 2'b01) || (bus.player == 2'b10)) begin
              state_q <= StScan;
            end else begin
              // Nothing can match an empty or invalid code, so report no-win immediately.
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StScan: begin
          if (match && (k_q == 2'd3)) begin
            win_q    <= 1'b1;
            anchor_q <= anchor_addr;
            dir_q    <= d_q;
            k_q      <= '0;
            state_q  <= StDone;
            done_q   <= 1'b1;
          end else if (match) begin
            k_q <= k_q + 2'd1;
          end else begin
            // Advance the combo. d is the fastest index, then c, then r.
            k_q <= '0;
            if (last_combo) begin
              r_q     <= '0;
              c_q     <= '0;
              d_q     <= '0;
              state_q <= StDone;
              done_q  <= 1'b1;
            end else if (d_q != 2'd3) begin
              d_q <= d_q + 2'd1;
            end else begin
              d_q <= '0;
              if (c_q != ColW'(COLS - 1)) begin
                c_q <= c_q + ColW'(1);
              end else begin
                c_q <= '0;
                r_q <= r_q + RowW'(1);
              end
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_connect4_win_scanner.sv
module tb_connect4_win_scanner;

  logic CLOCK_50 = 1'b0;
  logic Resetn;
  always #5 CLOCK_50 = ~CLOCK_50;

  connect4_win_scanner_if #(.ADDR_W(6)) bus ();

  connect4_win_scanner #(
    .ROWS   (6),
    .COLS   (7),
    .ADDR_W (6)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .Resetn   (Resetn),
    .bus      (bus.slave)
  );

  // Board store model: same-cycle read.
  logic [1:0] board [42];
  always_comb bus.rd_data = (bus.rd_addr < 6'd42) ? board[bus.rd_addr] : 2'b00;

  int total = 0;
  int bad   = 0;
  int cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_board();
    for (int i = 0; i < 42; i++) board[i] = 2'b00;
  endtask

  // One scan. cycles counts the edges after the start-sampling edge until done is seen.
  // When repulse_at >= 0, start is pulsed again (with player=10) during the scan.
  task automatic run_scan(input logic [1:0] p, input int repulse_at, output int cycles);
    @(negedge CLOCK_50);
    bus.player = p;
    bus.start  = 1'b1;
    @(posedge CLOCK_50);
    #1;
    bus.start = 1'b0;
    chk("busy_rise", 32'(bus.busy), 32'd1);
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < 1000) begin
      if (cycles == repulse_at) begin
        bus.start  = 1'b1;
        bus.player = 2'b10;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge CLOCK_50);
      #1;
      cycles++;
    end
    bus.start = 1'b0;
    chk("done_seen", 32'(bus.done), 32'd1);
    @(posedge CLOCK_50);
    #1;
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("busy_fall", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.start  = 1'b0;
    bus.player = 2'b00;
    Resetn     = 1'b0;
    clear_board();
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_win", 32'(bus.win), 32'd0);
    chk("rst_anchor", 32'(bus.win_anchor), 32'd0);
    chk("rst_dir", 32'(bus.win_dir), 32'd0);
    chk("rst_addr", 32'(bus.rd_addr), 32'd0);
    @(negedge CLOCK_50);
    Resetn = 1'b1;

    // Empty board: one cycle per combo.
    run_scan(2'b01, -1, cyc);
    chk("empty_cycles", 32'(cyc), 32'd168);
    chk("empty_win", 32'(bus.win), 32'd0);
    chk("empty_anchor", 32'(bus.win_anchor), 32'd0);
    chk("empty_dir", 32'(bus.win_dir), 32'd0);

    // Bottom row P1 at 35..38. Rows 0-4 take 140 cycles, then 4 cycles on the winning combo.
    clear_board();
    board[35] = 2'b01; board[36] = 2'b01; board[37] = 2'b01; board[38] = 2'b01;
    run_scan(2'b01, -1, cyc);
    chk("row_cycles", 32'(cyc), 32'd144);
    chk("row_win", 32'(bus.win), 32'd1);
    chk("row_anchor", 32'(bus.win_anchor), 32'd35);
    chk("row_dir", 32'(bus.win_dir), 32'd0);
    repeat (5) @(posedge CLOCK_50);
    #1;
    chk("row_hold_win", 32'(bus.win), 32'd1);
    chk("row_hold_anchor", 32'(bus.win_anchor), 32'd35);
    run_scan(2'b10, -1, cyc);
    chk("row_p2_win", 32'(bus.win), 32'd0);
    chk("row_p2_anchor", 32'(bus.win_anchor), 32'd0);

    // Vertical P2 in column 6.
    clear_board();
    board[20] = 2'b10; board[27] = 2'b10; board[34] = 2'b10; board[41] = 2'b10;
    run_scan(2'b10, -1, cyc);
    chk("col_win", 32'(bus.win), 32'd1);
    chk("col_anchor", 32'(bus.win_anchor), 32'd20);
    chk("col_dir", 32'(bus.win_dir), 32'd1);
    clear_board();
    board[13] = 2'b10; board[20] = 2'b10; board[27] = 2'b10; board[34] = 2'b10;
    board[41] = 2'b01;
    run_scan(2'b10, -1, cyc);
    chk("col2_win", 32'(bus.win), 32'd1);
    chk("col2_anchor", 32'(bus.win_anchor), 32'd13);
    chk("col2_dir", 32'(bus.win_dir), 32'd1);

    // Down-left diagonal from (0,3). The first 12 combos take 1 cycle each.
    // Then d0, d1 and d2 of (0,3) take 2 cycles each, and d3 takes 4 cycles.
    clear_board();
    board[3] = 2'b01; board[9] = 2'b01; board[15] = 2'b01; board[21] = 2'b01;
    run_scan(2'b01, -1, cyc);
    chk("dl_cycles", 32'(cyc), 32'd22);
    chk("dl_win", 32'(bus.win), 32'd1);
    chk("dl_anchor", 32'(bus.win_anchor), 32'd3);
    chk("dl_dir", 32'(bus.win_dir), 32'd3);
    clear_board();
    board[14] = 2'b01; board[22] = 2'b01; board[30] = 2'b01; board[38] = 2'b01;
    run_scan(2'b01, -1, cyc);
    chk("dr_win", 32'(bus.win), 32'd1);
    chk("dr_anchor", 32'(bus.win_anchor), 32'd14);
    chk("dr_dir", 32'(bus.win_dir), 32'd2);

    // Broken lines. Partial matches add k steps: 2+1+0+1 = 4 and 3+2+1+0 = 6.
    clear_board();
    board[35] = 2'b01; board[36] = 2'b01; board[37] = 2'b10; board[38] = 2'b01;
    run_scan(2'b01, -1, cyc);
    chk("brk1_cycles", 32'(cyc), 32'd172);
    chk("brk1_win", 32'(bus.win), 32'd0);
    clear_board();
    board[35] = 2'b01; board[36] = 2'b01; board[37] = 2'b01;
    run_scan(2'b01, -1, cyc);
    chk("brk2_cycles", 32'(cyc), 32'd174);
    chk("brk2_win", 32'(bus.win), 32'd0);

    // A start re-pulsed mid-scan (with a different player) must be ignored.
    clear_board();
    board[35] = 2'b01; board[36] = 2'b01; board[37] = 2'b01; board[38] = 2'b01;
    run_scan(2'b01, 20, cyc);
    chk("repulse_cycles", 32'(cyc), 32'd144);
    chk("repulse_win", 32'(bus.win), 32'd1);
    chk("repulse_anchor", 32'(bus.win_anchor), 32'd35);

    // Asynchronous reset mid-scan. After 49 edges the combo is (1,5,d1), so rd_addr = 12.
    clear_board();
    @(negedge CLOCK_50);
    bus.player = 2'b01;
    bus.start  = 1'b1;
    @(posedge CLOCK_50);
    #1;
    bus.start = 1'b0;
    repeat (49) @(posedge CLOCK_50);
    #1;
    chk("mid_addr", 32'(bus.rd_addr), 32'd12);
    #1;
    Resetn = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_win", 32'(bus.win), 32'd0);
    chk("mid_rst_anchor", 32'(bus.win_anchor), 32'd0);
    chk("mid_rst_dir", 32'(bus.win_dir), 32'd0);
    chk("mid_rst_addr", 32'(bus.rd_addr), 32'd0);
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    Resetn = 1'b1;
    board[35] = 2'b01; board[36] = 2'b01; board[37] = 2'b01; board[38] = 2'b01;
    run_scan(2'b01, -1, cyc);
    chk("post_rst_cycles", 32'(cyc), 32'd144);
    chk("post_rst_win", 32'(bus.win), 32'd1);
    chk("post_rst_anchor", 32'(bus.win_anchor), 32'd35);

    // Player code 00: done follows the accepting edge directly.
    run_scan(2'b00, -1, cyc);
    chk("p00_cycles", 32'(cyc), 32'd0);
    chk("p00_win", 32'(bus.win), 32'd0);
    chk("p00_anchor", 32'(bus.win_anchor), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
